// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter.
package freq_meter_pkg;

    typedef enum logic {FM_IDLE, FM_GATE} fm_state_t;

    // Gate length in system-clock cycles; zero flags an unusable gate_hz.
    function automatic int unsigned fm_gate_len(input int unsigned fast_hz,
                                                input int unsigned gate_hz);
        return (gate_hz == 0) ? 0 : fast_hz / gate_hz;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control and result bus between the frequency meter and its register wrapper.
interface freq_meter_if #(
    parameter int unsigned cnt_width = 24
) ();
    logic                 enable;
    logic [cnt_width-1:0] result;
    logic                 result_valid;
    logic                 result_ack;
    logic                 overflow;
    logic                 busy;

    modport master (
        input  enable,
        input  result_ack,
        output result,
        output result_valid,
        output overflow,
        output busy
    );

    modport slave (
        output enable,
        output result_ack,
        input  result,
        input  result_valid,
        input  overflow,
        input  busy
    );
endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs; q lags d by `stages` clocks.
module sync_chain #(
    parameter int unsigned width  = 1,
    parameter int unsigned stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    logic [stages-1:0][width-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[stages-2:0], d};
        end
    end

    assign q = ff[stages-1];
endmodule

// File: rtl/freq_meter.sv
// Counts synchronised rising edges of sig_in over a fixed gate window and
// publishes each count through a sticky valid/ack pair.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned fast_hz     = 1000000,
    parameter int unsigned gate_hz     = 10,
    parameter int unsigned cnt_width   = 24,
    parameter int unsigned sync_stages = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    freq_meter_if.master bus
);
    localparam int unsigned GATE_LEN = fm_gate_len(fast_hz, gate_hz);
    localparam int unsigned GATE_W   = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_LEN - 1);
    localparam logic [cnt_width-1:0] CNT_MAX   = '1;

    if (gate_hz > fast_hz || GATE_LEN < 2 || sync_stages < 2) begin : g_param_err
        $error("freq_meter: illegal parameter set");
    end

    logic                 sig_sync;
    logic                 sig_prev;
    logic                 rise_c;
    fm_state_t            state;
    fm_state_t            state_nxt;
    logic [GATE_W-1:0]    gate_cnt;
    logic [cnt_width-1:0] edge_cnt;
    logic [cnt_width-1:0] edge_sum_c;
    logic                 ovf;
    logic                 ovf_hit_c;
    logic                 count_c;
    logic                 publish_c;
    logic                 clear_c;

    sync_chain #(
        .width  (1),
        .stages (sync_stages)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .q   (sig_sync)
    );

    // Edge history runs in every state so a fresh gate never sees a stale edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig_sync;
        end
    end

    assign rise_c     = sig_sync & ~sig_prev;
    assign ovf_hit_c  = rise_c & (edge_cnt == CNT_MAX);
    assign edge_sum_c = (rise_c && edge_cnt != CNT_MAX) ? edge_cnt + cnt_width'(1) : edge_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FM_IDLE: if (bus.enable)  state_nxt = FM_GATE;
            FM_GATE: if (!bus.enable) state_nxt = FM_IDLE;
            default: state_nxt = FM_IDLE;
        endcase
    end

    // The gate's last cycle publishes whatever enable does; enable only picks the next state.
    always_comb begin
        count_c   = 1'b0;
        publish_c = 1'b0;
        clear_c   = 1'b0;
        if (state == FM_GATE) begin
            count_c   = 1'b1;
            publish_c = (gate_cnt == GATE_LAST);
            clear_c   = (gate_cnt == GATE_LAST) || !bus.enable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (clear_c) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (count_c) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_sum_c;
            ovf      <= ovf | ovf_hit_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.busy <= (state_nxt == FM_GATE);
            if (publish_c) begin
                bus.result       <= edge_sum_c;
                bus.overflow     <= ovf | ovf_hit_c;
                bus.result_valid <= 1'b1;
            end else if (bus.result_ack) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// Randomised bench for freq_meter: two counter widths share one stimulus and
// are checked against a window-counting reference built from sig_in history.
module tb_freq_meter;
    localparam int G      = 100;
    localparam int S      = 2;
    localparam int MAXC   = 8000;
    localparam int MAX_A  = 255;
    localparam int MAX_B  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_in = 1'b0;
    logic enable = 1'b0;
    logic result_ack = 1'b0;

    freq_meter_if #(.cnt_width(8)) bus_a ();
    freq_meter_if #(.cnt_width(4)) bus_b ();

    assign bus_a.enable     = enable;
    assign bus_a.result_ack = result_ack;
    assign bus_b.enable     = enable;
    assign bus_b.result_ack = result_ack;

    freq_meter #(.fast_hz(1000), .gate_hz(10), .cnt_width(8), .sync_stages(S)) u_dut_a (
        .clk (clk), .rst (rst), .sig_in (sig_in), .bus (bus_a)
    );
    freq_meter #(.fast_hz(1000), .gate_hz(10), .cnt_width(4), .sync_stages(S)) u_dut_b (
        .clk (clk), .rst (rst), .sig_in (sig_in), .bus (bus_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: sig_in sampled at each edge, gates as edge-index windows.
    bit s_hist [MAXC];
    int k        = 0;
    int rst_edge = 0;
    bit m_busy   = 0;
    int e0       = 0;
    bit m_valid  = 0;
    int m_raw    = 0;
    bit pub_now  = 0;

    int mode  = 0;
    int per   = 10;
    int ph    = 0;
    bit rnd_ctl = 0;

    function automatic int s_at(input int idx);
        if (idx <= rst_edge || idx < 0) return 0;
        return int'(s_hist[idx]);
    endfunction

    // Rising transitions seen by the meter during the G cycles after gate start e.
    function automatic int window_rises(input int e);
        int n = 0;
        for (int j = e + 1; j <= e + G; j++)
            if (s_at(j - S) == 1 && s_at(j - S - 1) == 0) n++;
        return n;
    endfunction

    task automatic model_update();
        pub_now = 0;
        if (m_busy && k == e0 + G) begin
            m_raw   = window_rises(e0);
            m_valid = 1;
            pub_now = 1;
            if (enable) e0 = k;
            else        m_busy = 0;
        end else if (m_busy && !enable) begin
            m_busy = 0;
        end else if (!m_busy && enable) begin
            m_busy = 1;
            e0     = k;
        end
        if (!pub_now && result_ack) m_valid = 0;
    endtask

    task automatic compare_all();
        check("busy_a",  bus_a.busy,         m_busy);
        check("valid_a", bus_a.result_valid, m_valid);
        check("result_a", bus_a.result,      (m_raw > MAX_A) ? MAX_A : m_raw);
        check("ovf_a",   bus_a.overflow,     m_raw > MAX_A);
        check("busy_b",  bus_b.busy,         m_busy);
        check("valid_b", bus_b.result_valid, m_valid);
        check("result_b", bus_b.result,      (m_raw > MAX_B) ? MAX_B : m_raw);
        check("ovf_b",   bus_b.overflow,     m_raw > MAX_B);
    endtask

    task automatic drive_sig();
        case (mode)
            0: sig_in = 1'b0;
            1: begin
                sig_in = (ph < per / 2);
                ph     = (ph + 1) % per;
            end
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
        if (rnd_ctl) begin
            enable     = ($urandom_range(0, 149) != 0);
            result_ack = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        s_hist[k] = sig_in;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_raw = 0; pub_now = 0;
            rst_edge = k;
        end else begin
            model_update();
        end
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_sig();
            step();
        end
    endtask

    task automatic set_square(input int p);
        mode = 1; per = p; ph = 0;
    endtask

    initial begin
        bit hit;

        run(3);
        rst = 1'b0;

        // Steady square waves at several rates, gates back to back.
        enable = 1'b1;
        set_square(10); run(250);
        check("basic_10", bus_a.result, 10);
        set_square(2);  run(250);
        check("fastest_50", bus_a.result, 50);
        set_square(4);  run(250);
        check("sat_b_15", bus_b.result, 15);
        check("sat_b_ovf", bus_b.overflow, 1);
        check("p4_a_25", bus_a.result, 25);
        mode = 0; run(250);
        check("low_b_0", bus_b.result, 0);
        check("low_b_ovf", bus_b.overflow, 0);

        // Ack the cycle after a publish.
        set_square(10);
        hit = 0;
        for (int i = 0; i < 3 * G && !hit; i++) begin run(1); hit = pub_now; end
        check("pub_seen", hit, 1);
        run(150);
        hit = 0;
        for (int i = 0; i < 3 * G && !hit; i++) begin run(1); hit = pub_now; end
        result_ack = 1'b1; run(1); result_ack = 1'b0;
        check("ack_clears", bus_a.result_valid, 0);
        check("ack_holds", bus_a.result, 10);

        // Ack landing in a publish cycle keeps valid set.
        hit = 0;
        for (int i = 0; i < 3 * G && !hit; i++) begin
            run(1);
            hit = (m_busy && k + 1 == e0 + G);
        end
        check("pred_pub", hit, 1);
        result_ack = 1'b1; run(1); result_ack = 1'b0;
        check("ack_pub_valid", bus_a.result_valid, 1);
        check("ack_pub_pub", pub_now, 1);

        // Abort at gate cycle 50, then re-enable and time the first publish.
        result_ack = 1'b1; run(1); result_ack = 1'b0;
        hit = 0;
        for (int i = 0; i < 3 * G && !hit; i++) begin
            run(1);
            hit = (m_busy && k - e0 == 49);
        end
        check("abort_at50", hit, 1);
        enable = 1'b0; run(1);
        check("abort_busy", bus_a.busy, 0);
        run(30);
        check("abort_nopub", bus_a.result_valid, 0);
        enable = 1'b1; run(1);
        check("reen_busy", bus_a.busy, 1);
        run(G - 1);
        check("reen_early", bus_a.result_valid, 0);
        run(1);
        check("reen_pub", bus_a.result_valid, 1);
        check("reen_cnt", bus_a.result, 10);

        // Random signal, enable drops and acks.
        mode = 2; rnd_ctl = 1; run(1500);
        rnd_ctl = 0; enable = 1'b1; result_ack = 1'b0;

        // Asynchronous reset mid-gate with a pending result.
        set_square(10);
        hit = 0;
        for (int i = 0; i < 4 * G && !hit; i++) begin
            run(1);
            hit = (m_valid && m_busy && k - e0 == 40);
        end
        check("rst_setup", hit, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_result", bus_a.result, 0);
        check("arst_valid", bus_a.result_valid, 0);
        check("arst_busy", bus_a.busy, 0);
        run(2);
        rst = 1'b0;
        run(250);
        check("post_rst_cnt", bus_a.result, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
